alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> DONE, giving one op per three cycles.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [3:0]       cap_op;
    logic             cap_id;
    logic             cap_illegal;
    logic             last_grant;

    logic             grant0;
    logic             grant1;
    logic [3:0]       sel_op;
    logic             sel_legal;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

    // Round-robin grant, only offered while idle; a tie goes to whoever was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && !grant0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign sel_legal  = op_legal(sel_op);

    // The ALU only ever sees captured operands; illegal codes are parked as 0000.
    assign alu_a  = cap_a;
    assign alu_b  = cap_b;
    assign alu_op = cap_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cap_a       <= '0;
            cap_b       <= '0;
            cap_op      <= 4'b0000;
            cap_id      <= 1'b0;
            cap_illegal <= 1'b0;
            last_grant  <= 1'b1;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        cap_a       <= grant1 ? req1_a : req0_a;
                        cap_b       <= grant1 ? req1_b : req0_b;
                        cap_op      <= sel_legal ? sel_op : 4'b0000;
                        cap_id      <= grant1;
                        cap_illegal <= !sel_legal;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= cap_illegal ? '0 : alu_result;
                    rsp_zero   <= !cap_illegal && alu_zero;
                    rsp_err    <= cap_illegal;
                    rsp0_valid <= !cap_id;
                    rsp1_valid <= cap_id;
                    state      <= DONE;
                end
                DONE: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    last_grant <= cap_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
